// File: rtl/cbrt_param.sv
// Iterative integer cube root: floor(cbrt(x_i)) one result bit per clock, restoring digit method.
// Optional remainder output rem_o = x_i - result^3 when CBRT_REM_EN is defined.
module cbrt_param #(
  parameter int XW = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [XW-1:0]          x_i,
  output logic [(XW+2)/3-1:0]    result,
`ifdef CBRT_REM_EN
  output logic [XW-1:0]          rem_o,
`endif
  output logic                   busy,
  output logic                   done
);

  localparam int RW = (XW + 2) / 3;
  localparam int IW = 3 * RW;
  localparam int YW = 2 * RW;
  localparam int KW = (RW > 1) ? $clog2(RW) : 1;
  // Headroom for the 3q + 6y + 1 sum before it is shifted into place.
  localparam int WW = IW + 4;

  logic [IW-1:0] rem;
  logic [RW-1:0] y;
  logic [YW-1:0] ysq;
  logic [KW-1:0] k;

  logic [RW-1:0] y2, y_nx;
  logic [YW-1:0] q, ysq_nx;
  logic [KW+1:0] s;
  logic [WW-1:0] b, bs;
  logic          take;
  logic [IW-1:0] rem_nx;

  // One digit step: try appending a 1 bit to the root; (2y+1)^3 - (2y)^3 = 12y^2 + 6y + 1.
  always_comb begin
    y2     = y << 1;
    q      = ysq << 2;
    s      = ({2'b00, k} << 1) + {2'b00, k};
    b      = (WW'(q) << 1) + WW'(q) + (WW'(y2) << 1) + WW'(y2) + WW'(1);
    bs     = b << s;
    take   = (WW'(rem) >= bs);
    rem_nx = take ? (rem - bs[IW-1:0]) : rem;
    y_nx   = take ? (y2 | RW'(1)) : y2;
    // (2y+1)^2 = 4y^2 + 4y + 1, kept without a multiplier.
    ysq_nx = take ? (q + (YW'(y2) << 1) + YW'(1)) : q;
  end

`ifdef CBRT_REM_EN
  logic [XW-1:0] rem_out;
  assign rem_o = rem_out;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem     <= '0;
      y       <= '0;
      ysq     <= '0;
      k       <= '0;
      result  <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
`ifdef CBRT_REM_EN
      rem_out <= '0;
`endif
    end else begin
      done <= 1'b0;
      if (!busy) begin
        if (start) begin
          rem  <= IW'(x_i);
          y    <= '0;
          ysq  <= '0;
          k    <= KW'(RW - 1);
          busy <= 1'b1;
        end
      end else begin
        rem <= rem_nx;
        y   <= y_nx;
        ysq <= ysq_nx;
        if (k != '0) begin
          k <= k - KW'(1);
        end else begin
          busy    <= 1'b0;
          done    <= 1'b1;
          result  <= y_nx;
`ifdef CBRT_REM_EN
          rem_out <= rem_nx[XW-1:0];
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_cbrt_param.sv
// Bench for cbrt_param: XW=8/12/16 instances checked each cycle against a transaction-level model.
// Remainder checks are compiled in only when CBRT_REM_EN is defined.
module tb_cbrt_param;

  localparam int N = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        s0, s1, s2;
  logic [7:0]  x0;
  logic [11:0] x1;
  logic [15:0] x2;
  logic [2:0]  r0;
  logic [3:0]  r1;
  logic [5:0]  r2;
  logic        b0, b1, b2, d0, d1, d2;
`ifdef CBRT_REM_EN
  logic [7:0]  q0;
  logic [11:0] q1;
  logic [15:0] q2;
`endif

  cbrt_param #(.XW(8)) u_x8 (
    .clk(clk), .rst(rst), .start(s0), .x_i(x0), .result(r0),
`ifdef CBRT_REM_EN
    .rem_o(q0),
`endif
    .busy(b0), .done(d0));

  cbrt_param #(.XW(12)) u_x12 (
    .clk(clk), .rst(rst), .start(s1), .x_i(x1), .result(r1),
`ifdef CBRT_REM_EN
    .rem_o(q1),
`endif
    .busy(b1), .done(d1));

  cbrt_param #(.XW(16)) u_x16 (
    .clk(clk), .rst(rst), .start(s2), .x_i(x2), .result(r2),
`ifdef CBRT_REM_EN
    .rem_o(q2),
`endif
    .busy(b2), .done(d2));

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  function automatic int rw_of(int i);
    return (i == 0) ? 3 : (i == 1) ? 4 : 6;
  endfunction

  function automatic int xmask(int i);
    return (i == 0) ? 32'hFF : (i == 1) ? 32'hFFF : 32'hFFFF;
  endfunction

  function automatic longint icbrt(longint x);
    longint r = 0;
    while ((r + 1) * (r + 1) * (r + 1) <= x) r++;
    return r;
  endfunction

  function automatic longint cube(longint r);
    return r * r * r;
  endfunction

  function automatic int dut_res(int i);
    case (i) 0: return int'(r0); 1: return int'(r1); default: return int'(r2); endcase
  endfunction
  function automatic int dut_busy(int i);
    case (i) 0: return int'(b0); 1: return int'(b1); default: return int'(b2); endcase
  endfunction
  function automatic int dut_done(int i);
    case (i) 0: return int'(d0); 1: return int'(d1); default: return int'(d2); endcase
  endfunction
  function automatic int dut_start(int i);
    case (i) 0: return int'(s0); 1: return int'(s1); default: return int'(s2); endcase
  endfunction
  function automatic int dut_x(int i);
    case (i) 0: return int'(x0); 1: return int'(x1); default: return int'(x2); endcase
  endfunction
`ifdef CBRT_REM_EN
  function automatic int dut_rem(int i);
    case (i) 0: return int'(q0); 1: return int'(q1); default: return int'(q2); endcase
  endfunction
`endif

  task automatic drive(int i, bit s, int x);
    case (i)
      0: begin s0 = s; x0 = 8'(x);  end
      1: begin s1 = s; x1 = 12'(x); end
      default: begin s2 = s; x2 = 16'(x); end
    endcase
  endtask

  task automatic chk(string nm, int inst, longint act, longint exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s[inst %0d] @%0t: got %0d, expected %0d", nm, inst, $time, act, exp);
    end
  endtask

  // Transaction model: a request occupies RW cycles, then the floor cube root appears with done.
  int m_left[N];
  int m_x[N];
  int m_res[N];
  int m_rem[N];
  int m_done[N];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        m_left[i] <= 0; m_x[i] <= 0; m_res[i] <= 0; m_rem[i] <= 0; m_done[i] <= 0;
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        m_done[i] <= 0;
        if (m_left[i] == 0) begin
          if (dut_start(i) != 0) begin
            m_left[i] <= rw_of(i);
            m_x[i]    <= dut_x(i);
          end
        end else begin
          m_left[i] <= m_left[i] - 1;
          if (m_left[i] == 1) begin
            m_done[i] <= 1;
            m_res[i]  <= int'(icbrt(m_x[i]));
            m_rem[i]  <= m_x[i] - int'(cube(icbrt(m_x[i])));
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en && !rst) begin
      for (int i = 0; i < N; i++) begin
        chk("cyc_busy", i, dut_busy(i), (m_left[i] > 0) ? 1 : 0);
        chk("cyc_done", i, dut_done(i), m_done[i]);
        chk("cyc_result", i, dut_res(i), m_res[i]);
`ifdef CBRT_REM_EN
        chk("cyc_rem", i, dut_rem(i), m_rem[i]);
`endif
      end
    end
  end

  // One request from idle; optionally a second start raised on busy cycle at2 (must be ignored).
  task automatic run(int i, int x, int at2, int x2, int er, int erem);
    int n = 0;
    drive(i, 1'b1, x);
    @(negedge clk);
    drive(i, 1'b0, x);
    while (dut_busy(i) != 0 && n < 40) begin
      n++;
      if (n == at2) drive(i, 1'b1, x2);
      else          drive(i, 1'b0, (at2 > 0) ? x2 : x);
      @(negedge clk);
    end
    drive(i, 1'b0, x);
    chk("busy_width", i, n, rw_of(i));
    chk("done_pulse", i, dut_done(i), 1);
    chk("result", i, dut_res(i), er);
`ifdef CBRT_REM_EN
    chk("rem", i, dut_rem(i), erem);
`else
    if (erem < 0) chk("rem_arg", i, erem, 0);
`endif
  endtask

  initial begin
    for (int i = 0; i < N; i++) drive(i, 1'b0, 0);
    repeat (2) @(negedge clk);
    for (int i = 0; i < N; i++) begin
      chk("rst_busy", i, dut_busy(i), 0);
      chk("rst_done", i, dut_done(i), 0);
      chk("rst_result", i, dut_res(i), 0);
`ifdef CBRT_REM_EN
      chk("rst_rem", i, dut_rem(i), 0);
`endif
    end
    rst = 1'b0;
    chk_en = 1'b1;

    chk("model_27", 0, icbrt(27), 3);
    chk("model_64000", 2, icbrt(64000), 40);
    chk("model_63999", 2, icbrt(63999), 39);
    chk("model_rem_65535", 2, 65535 - cube(icbrt(65535)), 1535);

    run(0, 27, 0, 0, 3, 0);
    run(0, 255, 0, 0, 6, 39);
    run(0, 26, 0, 0, 2, 18);
    run(0, 1, 0, 0, 1, 0);
    run(0, 0, 0, 0, 0, 0);
    run(2, 65535, 0, 0, 40, 1535);
    run(2, 64000, 0, 0, 40, 0);
    run(0, 216, 2, 8, 6, 0);

    // Abort x=125 during its second iteration cycle.
    drive(0, 1'b1, 125);
    @(negedge clk);
    drive(0, 1'b0, 125);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_busy", 0, dut_busy(0), 0);
    chk("abort_done", 0, dut_done(0), 0);
    chk("abort_result", 0, dut_res(0), 0);
`ifdef CBRT_REM_EN
    chk("abort_rem", 0, dut_rem(0), 0);
`endif
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("abort_idle", 0, dut_busy(0), 0);
    run(0, 125, 0, 0, 5, 0);

    // Random traffic on all instances, including starts held across completion.
    repeat (3000) begin
      for (int i = 0; i < N; i++) begin
        int xr;
        xr = ($urandom_range(0, 7) == 0) ? xmask(i) : int'($urandom) & xmask(i);
        drive(i, $urandom_range(0, 2) != 0, xr);
      end
      @(negedge clk);
    end
    for (int i = 0; i < N; i++) drive(i, 1'b0, 0);
    repeat (10) @(negedge clk);

    for (int x = 0; x < 256; x++)
      run(0, x, 0, 0, int'(icbrt(x)), x - int'(cube(icbrt(x))));
    for (int x = 0; x < 4096; x++)
      run(1, x, 0, 0, int'(icbrt(x)), x - int'(cube(icbrt(x))));

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cbrt_param.md
# cbrt_param

Parametrised iterative integer cube-root unit. It is the successor to the fixed 8-bit cube-root block, generalised to any input width XW. It computes floor(∛x) one result bit per clock using the restoring digit-by-digit method and needs no multiplier. It uses a start/busy handshake plus a one-cycle done pulse, and can optionally expose the remainder x − result³.

## Interface
- XW, default 8: input width, legal range 3..30.
- RW (localparam) = (XW+2)/3, integer division: result width; also the iteration count.
- IW (localparam) = 3*RW: internal compare/subtract width.
- clk  input  1  single clock; all registers update on its rising edge.
- rst  input  1  asynchronous, active-high reset; clears all state immediately.
- start  input  1  request pulse; accepted only when busy=0.
- x_i  input  XW  radicand; sampled only on the accepting edge.
- result  output  RW  floor(∛x); registered.
- rem_o  output  XW  x − result³; present only with CBRT_REM_EN.
- busy  output  1  high while iterating.
- done  output  1  one-cycle pulse when result updates.

## Operation
- Registers:
  - rem (IW): working remainder, loaded with zero-extended x_i.
  - y (RW): partial root.
  - ysq (2*RW): y².
  - k (counter 0..RW-1).
  - result, rem_out, busy, done.
- IDLE (busy=0):
  - If start=1 at the edge: rem←x_i, y←0, ysq←0, k←RW−1, busy←1.
  - Otherwise all registers hold.
- ITER (busy=1), one iteration per edge with s=3k:
  - y2=2y, q=4·ysq, b=3q+3·y2+1.
  - bs = b<<s, evaluated at IW bits; no overflow is possible.
  - If rem ≥ bs: rem←rem−bs, y←y2+1, ysq←q+2·y2+1.
  - Else: y←y2, ysq←q.
  - If k>0: k←k−1.
  - If k=0: busy←0, done←1, result←the new y value, rem_out←the new rem value (low XW bits).
- done is cleared on every edge where it was not just set.
- start while busy=1 is ignored: no restart, no queueing, and x_i is not resampled.
- result and rem_o hold their last completed values until the next completion. They do not change during iteration.
- x=0 yields result=0 and rem=0, and still takes the full RW cycles.
- The y² term is maintained only by shifts and adds; the block contains no `*` operator on variables.

## Timing
- Reset values: result=0, rem_o=0, busy=0, done=0; internal y, ysq, rem and k are 0.
- Edge E0 (start=1, busy=0): busy is high after E0.
- Iterations run on edges E1..E_RW.
- On edge E_RW: busy goes low, done goes high for one cycle, and result is valid.
- Busy stays high for exactly RW cycles. Latency from start to result is RW+1 edges including E0.
- Throughput: the next start is accepted on edge E_RW+1 at the earliest. A start held high through E_RW is accepted at E_RW+1.
- Reset asserted mid-operation aborts immediately: busy=0, done=0, result=0. The next computation starts only on a fresh accepted start after rst=0.
- Inputs are sampled only on rising clk edges while rst=0.

## Configuration
- CBRT_REM_EN defined:
  - rem_o port exists.
  - Driven from rem_out, which resets to 0 and updates with result.
- CBRT_REM_EN undefined:
  - rem_o port and the rem_out register are omitted.
  - All other behaviour and timing are identical.

## Test plan
- XW=8, x=27: busy high exactly 3 cycles → result=3, done one cycle, rem_o=0.
- XW=8, x sweeps 255, 26, 1, 0: results 6 (rem 39), 2 (rem 18), 1 (rem 0), 0 (rem 0).
- XW=16, x=65535: busy 6 cycles → result=40, rem_o=1535. For x=64000: result=40, rem_o=0.
- XW=8, start x=216, then start x=8 on the second busy cycle → result=6; the second request is ignored and busy falls at cycle 3.
- XW=8, rst pulsed on the 2nd iteration cycle of x=125 → outputs go to 0 at once. A new start with x=125 then gives result=5.
- Exhaustive check for XW=8 and XW=12: every x → result³ ≤ x < (result+1)³, rem_o = x − result³, busy width = RW.
